// File: rtl/enc_serializer.sv
// 8b/10b serializer: MSB-first shift-out, running-disparity register,
// and K28.5 comma insertion for sync, idle fill and dropped k_err words.
module enc_serializer #(
   parameter int SYNC_WORDS = 4,
   parameter int ERR_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [9:0]       data_in,
   input  logic             rdisp_in,
   input  logic             k_err_in,
   input  logic             valid_in,
   output logic             ready,
   output logic             rdisp_q,
   output logic             ser_out,
   output logic             word_start,
   output logic             comma_ins,
   output logic [ERR_W-1:0] err_cnt
);

   localparam logic [9:0] K_NEG = 10'b0011111010;
   localparam logic [9:0] K_POS = 10'b1100000101;
   localparam int SC_W = $clog2(SYNC_WORDS + 1);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SYNC_WORDS - 1);

   typedef enum logic {
      S_SYNC,
      S_RUN
   } state_t;

   state_t           state_q, state_d;
   logic [SC_W-1:0]  sync_cnt_q, sync_cnt_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [9:0]       shreg_q, shreg_d;
   logic             rdisp_d;
   logic [ERR_W-1:0] err_cnt_d;
   logic             word_start_d;
   logic             comma_d;
   logic             load;
   logic [9:0]       k_word;

   assign load    = (bit_cnt_q == 4'd9);
   assign k_word  = rdisp_q ? K_POS : K_NEG;
   assign ready   = (state_q == S_RUN) && load;
   assign ser_out = shreg_q[9];

   always_comb begin
      state_d      = state_q;
      sync_cnt_d   = sync_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      rdisp_d      = rdisp_q;
      err_cnt_d    = err_cnt;
      word_start_d = load;
      comma_d      = 1'b0;
      if (load) begin
         bit_cnt_d = 4'd0;
         unique case (state_q)
            S_SYNC: begin
               shreg_d    = k_word;
               rdisp_d    = ~rdisp_q;
               comma_d    = 1'b1;
               sync_cnt_d = sync_cnt_q + SC_W'(1);
               if (sync_cnt_q == SC_LAST)
                  state_d = S_RUN;
            end
            S_RUN: begin
               if (valid_in && !k_err_in) begin
                  shreg_d = data_in;
                  rdisp_d = rdisp_in;
               end else begin
                  // idle gap or illegal K code: fill with a comma
                  shreg_d = k_word;
                  rdisp_d = ~rdisp_q;
                  comma_d = 1'b1;
                  if (valid_in && err_cnt != '1)
                     err_cnt_d = err_cnt + ERR_W'(1);
               end
            end
            default: state_d = S_SYNC;
         endcase
      end else begin
         shreg_d   = {shreg_q[8:0], 1'b0};
         bit_cnt_d = bit_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_SYNC;
         sync_cnt_q <= '0;
         bit_cnt_q  <= 4'd9;
         shreg_q    <= '0;
         rdisp_q    <= 1'b0;
         err_cnt    <= '0;
         word_start <= 1'b0;
         comma_ins  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_cnt_q <= sync_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         rdisp_q    <= rdisp_d;
         err_cnt    <= err_cnt_d;
         word_start <= word_start_d;
         comma_ins  <= comma_d;
      end
   end

endmodule

// File: tb/tb_enc_serializer.sv
// Bench for enc_serializer: directed phases plus random traffic,
// checked every cycle against a word-timeline reference model.
module tb_enc_serializer;

   localparam int SW = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] data_in = '0;
   logic       rdisp_in = 1'b0;
   logic       k_err_in = 1'b0;
   logic       valid_in = 1'b0;

   logic       ready, rdisp_q, ser_out, word_start, comma_ins;
   logic [7:0] err_cnt;
   logic       ready2, rdisp_q2, ser_out2, word_start2, comma_ins2;
   logic [1:0] err_cnt2;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: time since reset edge and the current word
   int         m_t = 0;
   bit         m_rd = 0;
   int         m_e8 = 0;
   int         m_e2 = 0;
   logic [9:0] m_cur = '0;
   bit         m_com = 0;
   bit         m_rdy = 0;

   enc_serializer #(.SYNC_WORDS(SW)) u_dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in),
      .rdisp_in(rdisp_in), .k_err_in(k_err_in), .valid_in(valid_in),
      .ready(ready), .rdisp_q(rdisp_q), .ser_out(ser_out),
      .word_start(word_start), .comma_ins(comma_ins), .err_cnt(err_cnt)
   );

   enc_serializer #(.SYNC_WORDS(SW), .ERR_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in),
      .rdisp_in(rdisp_in), .k_err_in(k_err_in), .valid_in(valid_in),
      .ready(ready2), .rdisp_q(rdisp_q2), .ser_out(ser_out2),
      .word_start(word_start2), .comma_ins(comma_ins2), .err_cnt(err_cnt2)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] kw(bit rd);
      return rd ? 10'b1100000101 : 10'b0011111010;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s t=%0d: observed %0h expected %0h", tag, m_t, obs, exp);
      end
   endtask

   task automatic model_edge();
      if (!rst_n) begin
         m_t = 0; m_rd = 0; m_e8 = 0; m_e2 = 0;
         m_cur = '0; m_com = 0;
      end else begin
         m_t++;
         if (m_t % 10 == 1) begin
            if ((m_t - 1) / 10 < SW || !valid_in || k_err_in) begin
               m_cur = kw(m_rd);
               m_rd  = ~m_rd;
               m_com = 1;
               if ((m_t - 1) / 10 >= SW && valid_in && k_err_in) begin
                  if (m_e8 < 255) m_e8++;
                  if (m_e2 < 3) m_e2++;
               end
            end else begin
               m_cur = data_in;
               m_rd  = rdisp_in;
               m_com = 0;
            end
         end
      end
      m_rdy = (m_t % 10 == 0) && (m_t / 10 >= SW);
   endtask

   task automatic check();
      bit ws;
      logic sb;
      ws = (m_t >= 1) && ((m_t - 1) % 10 == 0);
      sb = (m_t == 0) ? 1'b0 : m_cur[9 - ((m_t - 1) % 10)];
      chk("ser_out", 32'(ser_out), 32'(sb));
      chk("word_start", 32'(word_start), 32'(ws));
      chk("comma_ins", 32'(comma_ins), 32'(ws && m_com));
      chk("ready", 32'(ready), 32'(m_rdy));
      chk("rdisp_q", 32'(rdisp_q), 32'(m_rd));
      chk("err_cnt", 32'(err_cnt), 32'(m_e8));
      chk("err_cnt_w2", 32'(err_cnt2), 32'(m_e2));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check();
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      bit prev_rdy;
      bit hold;
      int guard;
      @(negedge clk);
      rst_n = 1'b0;
      run(2);
      rst_n = 1'b1;
      // sync sequence then idle fill
      run(55);
      // steady D0.0 RD- stream
      valid_in = 1'b1;
      data_in  = 10'b1001110100;
      rdisp_in = 1'b0;
      run(40);
      // one idle word period, then data resumes
      valid_in = 1'b0;
      run(10);
      valid_in = 1'b1;
      run(30);
      // five k_err words saturate the narrow counter
      k_err_in = 1'b1;
      run(50);
      k_err_in = 1'b0;
      run(20);
      // random traffic with handshake hold rule
      prev_rdy = 1'b1;
      for (int i = 0; i < 600; i++) begin
         hold = valid_in && !prev_rdy;
         if (!hold) begin
            valid_in = ($urandom_range(0, 3) != 0);
            k_err_in = ($urandom_range(0, 5) == 0);
            data_in  = 10'($urandom);
            rdisp_in = 1'($urandom);
         end
         prev_rdy = m_rdy;
         cyc();
      end
      // reset in the middle of a data word
      valid_in = 1'b1;
      k_err_in = 1'b0;
      data_in  = 10'b1010110001;
      rdisp_in = 1'b1;
      guard = 0;
      while (!(m_t > 10 * SW && (m_t - 1) % 10 == 4 && !m_com)
             && guard < 200) begin
         cyc();
         guard++;
      end
      chk("midword_reached", 32'(guard < 200), 32'd1);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("rst_ser_out", 32'(ser_out), 32'd0);
      chk("rst_rdisp", 32'(rdisp_q), 32'd0);
      chk("rst_err", 32'(err_cnt), 32'd0);
      valid_in = 1'b0;
      run(60);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
